// File: rtl/mips_wb_pkg.sv
// Shared definitions for the MEM/WB writeback stage: widths, result-source
// and load-type encodings, and the pre-capture writeback entry.
package mips_wb_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  localparam logic [2:0] LT_W  = 3'd0;
  localparam logic [2:0] LT_B  = 3'd1;
  localparam logic [2:0] LT_BU = 3'd2;
  localparam logic [2:0] LT_H  = 3'd3;
  localparam logic [2:0] LT_HU = 3'd4;

  // Fully formatted result, computed ahead of the capture register.
  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
    logic              wen;
    logic              misaligned;
  } wb_entry_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-stage request and register-file write port of the writeback stage.
// master = MEM-stage / register-file side, slave = writeback stage.
interface writeback_stage_if;
  import mips_wb_pkg::*;

  logic              in_valid;
  logic              flush;
  logic              stall;
  logic              reg_write;
  logic [REG_AW-1:0] dest;
  logic [1:0]        wb_sel;
  logic [2:0]        load_type;
  logic [1:0]        byte_off;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pc_plus8;

  logic [REG_AW-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              regWen;
  logic              misalign_err;
  logic              fwd_valid;
  logic [31:0]       retire_count;

  modport master (
    output in_valid, flush, stall, reg_write, dest, wb_sel, load_type,
           byte_off, alu_result, mem_rdata, pc_plus8,
    input  writeReg, writeData, regWen, misalign_err, fwd_valid, retire_count
  );

  modport slave (
    input  in_valid, flush, stall, reg_write, dest, wb_sel, load_type,
           byte_off, alu_result, mem_rdata, pc_plus8,
    output writeReg, writeData, regWen, misalign_err, fwd_valid, retire_count
  );

endinterface

// File: rtl/load_align.sv
// Little-endian sub-word load alignment and extension, with misalignment
// detection. Purely combinational.
module load_align
  import mips_wb_pkg::*;
(
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [2:0]        load_type,
  input  logic [1:0]        byte_off,
  output logic [DATA_W-1:0] data,
  output logic              misaligned
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = mem_rdata[7:0];
    case (byte_off)
      2'd1:    byte_val = mem_rdata[15:8];
      2'd2:    byte_val = mem_rdata[23:16];
      2'd3:    byte_val = mem_rdata[31:24];
      default: byte_val = mem_rdata[7:0];
    endcase
    half_val = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Reserved load types fall through to the word case.
  always_comb begin
    data       = mem_rdata;
    misaligned = 1'b0;
    case (load_type)
      LT_B:  data = {{24{byte_val[7]}}, byte_val};
      LT_BU: data = {24'd0, byte_val};
      LT_H: begin
        data       = {{16{half_val[15]}}, half_val};
        misaligned = byte_off[0];
      end
      LT_HU: begin
        data       = {16'd0, half_val};
        misaligned = byte_off[0];
      end
      default: begin
        data       = mem_rdata;
        misaligned = |byte_off;
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MIPS MEM/WB pipeline register: selects and formats the result, then drives
// the register-file write port straight from flops, plus a retire counter.
module writeback_stage
  import mips_wb_pkg::WB_MEM, mips_wb_pkg::WB_LINK, mips_wb_pkg::wb_entry_t;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  writeback_stage_if.slave  wb
);

  logic [DATA_W-1:0] load_data;
  logic              load_misaligned;
  logic              cap;
  wb_entry_t         next_entry;

  logic [REG_AW-1:0] write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic              reg_wen_q;
  logic              misalign_q;
  logic [31:0]       retire_cnt;

  load_align u_align (
    .mem_rdata  (wb.mem_rdata),
    .load_type  (wb.load_type),
    .byte_off   (wb.byte_off),
    .data       (load_data),
    .misaligned (load_misaligned)
  );

  assign cap = wb.in_valid & ~wb.stall & ~wb.flush;

  // Misalignment only matters for loads; a faulting load writes nothing.
  always_comb begin
    next_entry      = '0;
    next_entry.dest = wb.dest;
    case (wb.wb_sel)
      WB_MEM:  next_entry.data = load_data;
      WB_LINK: next_entry.data = wb.pc_plus8;
      default: next_entry.data = wb.alu_result;
    endcase
    next_entry.misaligned = (wb.wb_sel == WB_MEM) & load_misaligned;
    if (next_entry.misaligned) begin
      next_entry.data = '0;
    end
    next_entry.wen = wb.reg_write & (|wb.dest) & ~next_entry.misaligned;
  end

  // Bubbles clear the strobes but leave the last index/data in place.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_wen_q    <= 1'b0;
      misalign_q   <= 1'b0;
      retire_cnt   <= '0;
    end else begin
      reg_wen_q  <= cap & next_entry.wen;
      misalign_q <= cap & next_entry.misaligned;
      if (cap) begin
        write_reg_q  <= next_entry.dest;
        write_data_q <= next_entry.data;
        retire_cnt   <= retire_cnt + 32'd1;
      end
    end
  end

  assign wb.writeReg     = write_reg_q;
  assign wb.writeData    = write_data_q;
  assign wb.regWen       = reg_wen_q;
  assign wb.fwd_valid    = reg_wen_q;
  assign wb.misalign_err = misalign_q;
  assign wb.retire_count = retire_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage using immediate assertions.
module tb_writeback_stage;

  logic Clk;
  logic Rst;
  int   assertCount;
  int   failCount;

  writeback_stage_if wbIf ();

  writeback_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .wb  (wbIf.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one MEM-stage request, let it be sampled, then settle past the edge.
  task automatic applyStimulus(input logic valid, input logic fl, input logic st,
                               input logic rw, input logic [4:0] dst,
                               input logic [1:0] sel, input logic [2:0] lt,
                               input logic [1:0] off, input logic [31:0] alu,
                               input logic [31:0] mem, input logic [31:0] pc);
    wbIf.in_valid   = valid;
    wbIf.flush      = fl;
    wbIf.stall      = st;
    wbIf.reg_write  = rw;
    wbIf.dest       = dst;
    wbIf.wb_sel     = sel;
    wbIf.load_type  = lt;
    wbIf.byte_off   = off;
    wbIf.alu_result = alu;
    wbIf.mem_rdata  = mem;
    wbIf.pc_plus8   = pc;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input string tag, input logic wen, input logic [4:0] idx,
                            input logic [31:0] data, input logic merr,
                            input logic [31:0] cnt);
    checkOutput({tag, ".regWen"},       {31'd0, wbIf.regWen},       {31'd0, wen});
    checkOutput({tag, ".fwd_valid"},    {31'd0, wbIf.fwd_valid},    {31'd0, wen});
    checkOutput({tag, ".writeReg"},     {27'd0, wbIf.writeReg},     {27'd0, idx});
    checkOutput({tag, ".writeData"},    wbIf.writeData,             data);
    checkOutput({tag, ".misalign_err"}, {31'd0, wbIf.misalign_err}, {31'd0, merr});
    checkOutput({tag, ".retire_count"}, wbIf.retire_count,          cnt);
  endtask

  localparam logic [31:0] MEMW = 32'h8070_F011;

  initial begin
    assertCount = 0;
    failCount   = 0;

    // Reset held for two edges while a valid write is presented.
    Rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 2'd0, 3'd0, 2'd0, 32'hAAAA_5555, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 2'd0, 3'd0, 2'd0, 32'hAAAA_5555, 32'd0, 32'd0);
    checkWrite("reset", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

    Rst = 1'b1;
    idle();
    checkWrite("postReset", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);
    checkWrite("aluFirst", 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 32'd1);

    // Sub-word loads from 0x8070_F011.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 2'd1, 3'd1, 2'd1, 32'd0, MEMW, 32'd0);
    checkWrite("lbOff1", 1'b1, 5'd8, 32'hFFFF_FFF0, 1'b0, 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 2'd1, 3'd2, 2'd3, 32'd0, MEMW, 32'd0);
    checkWrite("lbuOff3", 1'b1, 5'd9, 32'h0000_0080, 1'b0, 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 2'd1, 3'd3, 2'd2, 32'd0, MEMW, 32'd0);
    checkWrite("lhOff2", 1'b1, 5'd10, 32'hFFFF_8070, 1'b0, 32'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 2'd1, 3'd4, 2'd0, 32'd0, MEMW, 32'd0);
    checkWrite("lhuOff0", 1'b1, 5'd11, 32'h0000_F011, 1'b0, 32'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 2'd1, 3'd0, 2'd0, 32'd0, MEMW, 32'd0);
    checkWrite("lwOff0", 1'b1, 5'd12, MEMW, 1'b0, 32'd6);

    // Misaligned loads: no write, one-cycle error pulse, still retired.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 2'd1, 3'd0, 2'd2, 32'd0, MEMW, 32'd0);
    checkWrite("lwOff2", 1'b0, 5'd5, 32'd0, 1'b1, 32'd7);
    idle();
    checkOutput("lwOff2.pulseEnd", {31'd0, wbIf.misalign_err}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 2'd1, 3'd3, 2'd1, 32'd0, MEMW, 32'd0);
    checkWrite("lhOff1", 1'b0, 5'd5, 32'd0, 1'b1, 32'd8);

    // Write to r0 is suppressed but still retired.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0000_1234, 32'd0, 32'd0);
    checkWrite("dest0", 1'b0, 5'd0, 32'h0000_1234, 1'b0, 32'd9);

    // Flush and stall each turn a valid instruction into a bubble.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 2'd0, 3'd0, 2'd0, 32'h1111_1111, 32'd0, 32'd0);
    checkWrite("flushStall", 1'b0, 5'd0, 32'h0000_1234, 1'b0, 32'd9);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 2'd0, 3'd0, 2'd0, 32'h1111_1111, 32'd0, 32'd0);
    checkWrite("flushOnly", 1'b0, 5'd0, 32'h0000_1234, 1'b0, 32'd9);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 2'd0, 3'd0, 2'd0, 32'h1111_1111, 32'd0, 32'd0);
    checkWrite("stallOnly", 1'b0, 5'd0, 32'h0000_1234, 1'b0, 32'd9);

    // Back-to-back writes to r1..r3.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 2'd0, 3'd0, 2'd0, 32'h0000_0101, 32'd0, 32'd0);
    checkWrite("b2bR1", 1'b1, 5'd1, 32'h0000_0101, 1'b0, 32'd10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 2'd0, 3'd0, 2'd0, 32'h0000_0202, 32'd0, 32'd0);
    checkWrite("b2bR2", 1'b1, 5'd2, 32'h0000_0202, 1'b0, 32'd11);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h0000_0303, 32'd0, 32'd0);
    checkWrite("b2bR3", 1'b1, 5'd3, 32'h0000_0303, 1'b0, 32'd12);
    idle();
    checkOutput("b2bEnd.regWen", {31'd0, wbIf.regWen}, 32'd0);

    // Link and reserved result-source selections.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h5555_5555, 32'd0, 32'h0040_0008);
    checkWrite("jal", 1'b1, 5'd31, 32'h0040_0008, 1'b0, 32'd13);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd13, 2'd3, 3'd0, 2'd2, 32'h0BAD_CAFE, MEMW, 32'h0040_0010);
    checkWrite("wbSel3", 1'b1, 5'd13, 32'h0BAD_CAFE, 1'b0, 32'd14);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd14, 2'd0, 3'd0, 2'd0, 32'h0000_7777, 32'd0, 32'd0);
    checkWrite("noRegWrite", 1'b0, 5'd14, 32'h0000_7777, 1'b0, 32'd15);

    // Reset in the middle of traffic drops the in-flight instruction.
    Rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd15, 2'd0, 3'd0, 2'd0, 32'h0000_9999, 32'd0, 32'd0);
    checkWrite("midReset", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    Rst = 1'b1;
    idle();

    // Counter wrap from 0xFFFF_FFFF.
    force dut.retire_cnt = 32'hFFFF_FFFF;
    @(negedge Clk);
    release dut.retire_cnt;
    #1;
    checkOutput("preWrap.retire_count", wbIf.retire_count, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd16, 2'd0, 3'd0, 2'd0, 32'h0000_4242, 32'd0, 32'd0);
    checkWrite("wrap", 1'b1, 5'd16, 32'h0000_4242, 1'b0, 32'd0);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

MIPS MEM/WB pipeline register and writeback formatter, sitting directly upstream of the register file. It captures the memory-stage result on the rising Clk edge, selects ALU, load, or link data, and aligns and extends sub-word loads. It drives the register file's write port (writeReg/writeData/regWen) for one cycle per retired instruction; the register file commits on the following falling edge. It also exposes a forwarding tap and a retired-instruction counter.

## Interface
- Parameters:
  - DATA_W, 32, datapath width; fixed at 32 for this design.
  - REG_AW, 5, register index width.
- Ports:
  - Clk  in  1  clock; all state updates on posedge.
  - Rst  in  1  reset, synchronous, active-low.
  - in_valid  in  1  MEM stage holds a real instruction this cycle.
  - flush  in  1  discard the incoming instruction; loads a bubble.
  - stall  in  1  MEM stage stalled; loads a bubble.
  - reg_write  in  1  instruction writes a GPR.
  - dest  in  REG_AW  destination register index.
  - wb_sel  in  2  result source: ALU, MEM, or LINK.
  - load_type  in  3  W, B, BU, H, or HU.
  - byte_off  in  2  low address bits of the load.
  - alu_result  in  DATA_W  ALU result.
  - mem_rdata  in  DATA_W  raw aligned data memory word.
  - pc_plus8  in  DATA_W  link address for JAL/JALR.
  - writeReg  out  REG_AW  register file write index.
  - writeData  out  DATA_W  register file write data.
  - regWen  out  1  register file write enable.
  - misalign_err  out  1  one-cycle pulse on a misaligned load.
  - fwd_valid  out  1  WB forwarding entry valid (equals regWen).
  - retire_count  out  32  count of instructions retired.

## Operation
- Capture condition: cap = in_valid & ~stall & ~flush. flush has priority over stall, and both have priority over in_valid. A non-captured cycle loads a bubble (valid=0, regWen=0).
- wb_sel encodings:
  - 0 ALU: writeData = alu_result.
  - 1 MEM: writeData = formatted load.
  - 2 LINK: writeData = pc_plus8.
  - 3: reserved, treated as ALU.
- Load formatting is little-endian; the byte lane is byte_off.
  - B/BU: byte mem_rdata[8*off+7 : 8*off], sign- or zero-extended to 32 bits.
  - H/HU: halfword at byte_off[1]; misaligned when byte_off[0]=1.
  - W: misaligned when byte_off≠0.
  - Reserved load_type codes (5–7) are treated as W.
- Misaligned load: regWen=0, writeData=0, misalign_err=1 for that cycle. The instruction still counts as retired.
- dest==0: regWen is forced to 0. writeReg and writeData are still driven, and the instruction still counts as retired.
- regWen = valid & reg_write & (dest≠0) & ~misaligned.
- retire_count increments by 1 for every captured instruction and wraps from 0xFFFF_FFFF to 0.

## Timing
- Latency: 1 cycle. Inputs sampled at posedge N are driven on outputs throughout cycle N; the register file writes at the negedge inside cycle N.
- Formatting is computed before the capture register, so all outputs come straight from flops.
- regWen is high for exactly one cycle per captured writing instruction. Back-to-back captures give consecutive one-cycle writes with no gap.
- Reset (Rst=0 at posedge): valid, regWen, fwd_valid, misalign_err = 0; writeReg = 0; writeData = 0; retire_count = 0. Reset takes precedence over cap; an instruction in flight is dropped.
- Reset deasserted at posedge M: the first capture is possible at posedge M+1.

## Structure
- Shared package mips_wb_pkg holds:
  - WB_ALU/WB_MEM/WB_LINK constants (2-bit).
  - LT_W=0, LT_B=1, LT_BU=2, LT_H=3, LT_HU=4 (3-bit).
  - DATA_W and REG_AW.
- Sub-module load_align: combinational; inputs (mem_rdata, load_type, byte_off); outputs (data, misaligned). Instantiated once, ahead of the capture register.

## Test plan
- Reset: Rst=0 for 2 cycles with in_valid=1 → all outputs 0 and retire_count=0. Release Rst → retire_count=1 one cycle after the first capture.
- Byte loads: mem_rdata=0x8070_F011, LB off=1 → 0xFFFF_FFF0; LBU off=3 → 0x0000_0080; LH off=2 → 0xFFFF_8070.
- Misaligned loads: LW off=2, dest=5 → regWen=0, misalign_err=1 for one cycle, retire_count +1. LH off=1 → same behaviour.
- dest=0 suppression: ALU write with dest=0, alu_result=0x1234 → regWen=0, writeData=0x1234, retire_count +1.
- Flush and stall:
  - flush=1 and stall=1 together with in_valid=1 → bubble, count unchanged.
  - Three back-to-back ALU writes to r1, r2, r3 → regWen high for 3 consecutive cycles with matching writeReg.
  - JAL with pc_plus8=0x0040_0008, dest=31 → writeData=0x0040_0008.
- Counter wrap: preload retire_count to 0xFFFF_FFFF via force, capture one instruction → retire_count=0.
